neuron_stream_seq: RTL and testbench
====================================

Name: neuron_stream_seq

Overview:
- Parametrised, synthesisable stimulus/capture sequencer for an array of NUM_CH float_24_8 neurons.
- Holds per-channel data, tap and bias vectors in on-chip RAM and streams them to the neuron array over a valid/ready handshake.
- Applies a programmable bias lag and captures neuron results into a capture RAM.
- Replaces file-driven, counter-indexed stimulus with a host-loadable, length-programmable, back-pressure-aware engine.

Parameters:
- NUM_CH, 4, number of parallel neuron channels (1..16).
- DEPTH, 1024, vectors per channel in each stimulus and capture RAM (power of 2).
- BIAS_LAG, 1, vectors by which bias index trails data/tap index (0..7).
- DRAIN_TIMEOUT, 256, cycles allowed in DRAIN with no new result before aborting.
- AW (localparam), clog2(DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- length  in  AW+1  vectors per run, 1..DEPTH; sampled on start.
- load_we  in  1  stimulus RAM write strobe; ignored while busy.
- load_sel  in  2  0 = data, 1 = tap, 2 = bias, 3 = reserved (write dropped).
- load_ch  in  4  channel index; writes with load_ch >= NUM_CH are dropped.
- load_addr  in  AW  vector index.
- load_wdata  in  32  float_24_8 word.
- stim_valid  out  1  stimulus beat valid.
- stim_ready  in  1  neuron array accepts beat.
- data_out  out  NUM_CH*32  per-channel data; channel k at [32k+31:32k].
- tap_out  out  NUM_CH*32  per-channel tap.
- bias_out  out  NUM_CH*32  per-channel lagged bias.
- res_valid  in  1  result beat from the neuron array; no back-pressure.
- res_data  in  NUM_CH*32  per-channel neuron out.
- cap_addr  in  AW  capture RAM read address.
- cap_rdata  out  NUM_CH*32  capture word, 1-cycle registered read.
- cap_count  out  AW+1  results captured this run.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  sticky; high in DONE.
- timeout  out  1  sticky; set when DRAIN aborts.

Behaviour:
- Reset values (asynchronous, active-low): all outputs 0, FSM = IDLE, issue and capture indices 0. RAM contents are not reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start.
  - length latched; a length of 0 or greater than DEPTH clamps to DEPTH.
  - done, timeout and cap_count clear.
- RUN:
  - Issue index i walks 0..length-1.
  - Beat i: data_out = data[i], tap_out = tap[i], bias_out = bias[i-BIAS_LAG] for i >= BIAS_LAG, else 0.
  - RAMs are registered-read. A 2-entry output skid buffer gives 1 beat/cycle while stim_ready = 1.
  - First stim_valid appears 2 cycles after start.
  - Handshake: stim_valid and all payloads hold stable until stim_valid && stim_ready. The index advances only on transfer. Valid never drops without a transfer.
  - RUN -> DRAIN after beat length-1 transfers.
- Capture, active in RUN and DRAIN:
  - Each res_valid writes res_data to cap[cap_count] and increments cap_count.
  - Beats beyond length are ignored; cap_count saturates at length.
  - res_valid in IDLE or DONE is ignored.
- DRAIN:
  - -> DONE when cap_count == length.
  - DRAIN_TIMEOUT consecutive cycles with no res_valid -> DONE with timeout = 1.
  - A capture of the final result and a timeout expiry on the same cycle: capture wins, timeout stays 0.
- DONE:
  - done = 1, busy = 0.
  - start begins a new run, following the same rules as IDLE.
- start while busy is ignored.
- load_we while busy is dropped. A load on the same cycle as start is performed, and start still takes effect.
- cap_rdata is readable in any state. A read and a write to the same address on the same cycle returns old data.
- Reset asserted mid-run: immediate return to IDLE, stim_valid = 0, captured data is retained but undefined in count.

Optional Feature:
- Macro: NEURON_STREAM_CRC_EN.
- With it defined:
  - Adds output port crc  out  32, CRC-32 (polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection).
  - The CRC covers every captured res_data word, channel 0 first, in capture order.
  - crc clears on start and is final when done rises.
- Without it: the port and logic are absent, and cap_count/done behaviour is identical.

Decomposition:
- Shared package neuron_pkg holds:
  - float_24_8 typedef (32-bit);
  - the load_sel encodings LOAD_DATA/LOAD_TAP/LOAD_BIAS;
  - FSM state enum;
  - CRC polynomial constant.
- One sub-module, neuron_stream_skid: 2-entry valid/ready skid buffer, parametrised on payload width (3*NUM_CH*32).

Test Plan:
- NUM_CH = 4, length = 8, stim_ready = 1, all loaded data[i] = i, bias[i] = 0x100+i -> 8 consecutive beats starting 2 cycles after start; beat 0 bias = 0, beat 3 bias = 0x102.
- Same run with stim_ready toggling 1/0 every cycle -> payloads stable while stalled, exactly 8 transfers, no duplicate or skipped index.
- Neuron model echoing data with 5-cycle latency -> DONE 5 cycles after the last transfer, cap_count = 8, cap[i] readback = i.
- Model drops last result, DRAIN_TIMEOUT = 16 -> done = 1 and timeout = 1 exactly 16 cycles after the last res_valid; cap_count = 7.
- reset low in RUN at beat 3, then start with length = 2 -> stim_valid = 0 during reset; new run issues 2 beats and cap_count = 2.
- Edge cases, one run: length = 0 -> DEPTH beats; load_we with load_ch = 5 at NUM_CH = 4 -> RAM unchanged; start while busy -> ignored.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types, load-select encodings, sequencer states and CRC-32 helper
// for the neuron stimulus/capture sequencer.
package neuron_pkg;

    typedef logic [31:0] float_24_8;

    localparam logic [1:0] LOAD_DATA = 2'd0;
    localparam logic [1:0] LOAD_TAP  = 2'd1;
    localparam logic [1:0] LOAD_BIAS = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    // MSB-first, non-reflected CRC-32 over one 32-bit word
    function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] word);
        logic [31:0] c;
        c = crc;
        for (int i = 31; i >= 0; i--)
            c = (c[31] ^ word[i]) ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/neuron_stream_skid.sv
// neuron_stream_skid: 2-entry valid/ready skid buffer with registered outputs; the
// producer watches level and only pushes when an entry will be free.
module neuron_stream_skid #(
    parameter int W = 384
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   level
);

    logic [W-1:0] spare;
    logic         push;
    logic         pop;

    always_comb begin
        out_valid = level != 2'd0;
        push      = in_valid && level != 2'd2;
        pop       = out_valid && out_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
            spare    <= '0;
            level    <= '0;
        end else begin
            if (pop ? (level[1] || push) : (push && level == 2'd0))
                out_data <= level[1] ? spare : in_data;
            if (push && !pop && level == 2'd1)
                spare <= in_data;
            level <= level + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/neuron_stream_seq.sv
// neuron_stream_seq: host-loadable stimulus/capture sequencer for NUM_CH neurons.
// Define NEURON_STREAM_CRC_EN to add a CRC-32 over all captured results (crc port).
module neuron_stream_seq
    import neuron_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DEPTH         = 1024,
    parameter int BIAS_LAG      = 1,
    parameter int DRAIN_TIMEOUT = 256,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW:0]          length,
    input  logic                 load_we,
    input  logic [1:0]           load_sel,
    input  logic [3:0]           load_ch,
    input  logic [AW-1:0]        load_addr,
    input  logic [31:0]          load_wdata,
    output logic                 stim_valid,
    input  logic                 stim_ready,
    output logic [NUM_CH*32-1:0] data_out,
    output logic [NUM_CH*32-1:0] tap_out,
    output logic [NUM_CH*32-1:0] bias_out,
    input  logic                 res_valid,
    input  logic [NUM_CH*32-1:0] res_data,
    input  logic [AW-1:0]        cap_addr,
    output logic [NUM_CH*32-1:0] cap_rdata,
    output logic [AW:0]          cap_count,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
`ifdef NEURON_STREAM_CRC_EN
    ,
    output logic [31:0]          crc
`endif
);

    localparam int W  = NUM_CH * 32;
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LAG_W   = (AW + 1)'(BIAS_LAG);
    localparam logic [AW:0] ONE     = (AW + 1)'(1);

    state_t        state;
    logic [AW:0]   len;
    logic [AW:0]   len_in;
    logic [AW:0]   fetch_idx;
    logic [AW:0]   fetch_base;
    logic [AW:0]   issue_idx;
    logic [AW-1:0] rd_addr;
    logic [TW-1:0] idle_cnt;
    logic [1:0]    level;
    logic [1:0]    occ;
    logic          rd_vld;
    logic          rd_zero;
    logic          start_fire;
    logic          running;
    logic          fetch_go;
    logic          pop;
    logic          cap_we;
    logic          final_cap;
    logic          load_ok;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  rd_tap;
    logic [W-1:0]  rd_bias;
    logic [3*W-1:0] pay_in;
    logic [3*W-1:0] pay_out;

    // occ counts beats held or in flight after this edge; a fetch lands in the skid next cycle
    always_comb begin
        start_fire = start && (state == IDLE || state == DONE);
        running    = state == RUN || state == DRAIN;
        len_in     = (length == '0 || length > DEPTH_W) ? DEPTH_W : length;
        fetch_base = start_fire ? '0 : fetch_idx;
        rd_addr    = fetch_base[AW-1:0];
        pop        = stim_valid && stim_ready;
        occ        = level + {1'b0, rd_vld} - {1'b0, pop};
        fetch_go   = start_fire || (state == RUN && fetch_idx < len && occ < 2'd2);
        cap_we     = res_valid && running && cap_count < len;
        final_cap  = cap_we && cap_count == len - ONE;
        load_ok    = load_we && !running && {1'b0, load_ch} < 5'(NUM_CH) && load_sel != 2'd3;
        pay_in     = {rd_zero ? {W{1'b0}} : rd_bias, rd_tap, rd_data};
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        float_24_8 data_ram [DEPTH];
        float_24_8 tap_ram  [DEPTH];
        float_24_8 bias_ram [DEPTH];
        float_24_8 cap_ram  [DEPTH];
        float_24_8 d_q, t_q, b_q, c_q;
        logic      wr;
        assign wr = load_ok && load_ch == 4'(c);
        always_ff @(posedge clk) begin
            if (wr && load_sel == LOAD_DATA) data_ram[load_addr] <= load_wdata;
            if (wr && load_sel == LOAD_TAP)  tap_ram[load_addr]  <= load_wdata;
            if (wr && load_sel == LOAD_BIAS) bias_ram[load_addr] <= load_wdata;
            if (cap_we) cap_ram[cap_count[AW-1:0]] <= res_data[32*c +: 32];
            if (fetch_go) begin
                d_q <= data_ram[rd_addr];
                t_q <= tap_ram[rd_addr];
                b_q <= bias_ram[rd_addr - AW'(BIAS_LAG)];
            end
        end
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) c_q <= '0;
            else        c_q <= cap_ram[cap_addr];
        end
        assign rd_data[32*c +: 32]   = d_q;
        assign rd_tap[32*c +: 32]    = t_q;
        assign rd_bias[32*c +: 32]   = b_q;
        assign cap_rdata[32*c +: 32] = c_q;
    end

    neuron_stream_skid #(.W(3 * W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_vld),
        .in_data   (pay_in),
        .out_valid (stim_valid),
        .out_ready (stim_ready),
        .out_data  (pay_out),
        .level     (level)
    );

    assign {bias_out, tap_out, data_out} = pay_out;

`ifdef NEURON_STREAM_CRC_EN
    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc;
        for (int c = 0; c < NUM_CH; c++)
            crc_next = crc32_word(crc_next, res_data[32*c +: 32]);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len       <= '0;
            fetch_idx <= '0;
            issue_idx <= '0;
            rd_vld    <= 1'b0;
            rd_zero   <= 1'b0;
            cap_count <= '0;
            idle_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
`ifdef NEURON_STREAM_CRC_EN
            crc       <= '0;
`endif
        end else begin
            rd_vld <= fetch_go;
            if (fetch_go) begin
                fetch_idx <= fetch_base + ONE;
                rd_zero   <= fetch_base < LAG_W;
            end
            if (cap_we) cap_count <= cap_count + ONE;
            idle_cnt <= (res_valid || state != DRAIN) ? '0 : idle_cnt + TW'(1);
`ifdef NEURON_STREAM_CRC_EN
            if (cap_we) crc <= crc_next;
`endif
            if (start_fire) begin
                state     <= RUN;
                len       <= len_in;
                issue_idx <= '0;
                cap_count <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
                timeout   <= 1'b0;
`ifdef NEURON_STREAM_CRC_EN
                crc       <= CRC_INIT;
`endif
            end else if (state == RUN) begin
                if (pop) issue_idx <= issue_idx + ONE;
                if (pop && issue_idx == len - ONE) state <= DRAIN;
            end else if (state == DRAIN) begin
                // a final capture on the expiry cycle takes priority over the timeout
                if (final_cap || cap_count == len) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else if (!res_valid && idle_cnt == TW'(DRAIN_TIMEOUT - 1)) begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_stream_seq.sv
// tb_neuron_stream_seq: directed bench for neuron_stream_seq with an echoing neuron
// model of 5-cycle latency; inputs driven and outputs sampled on the falling edge.
module tb_neuron_stream_seq;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int W      = NUM_CH * 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   length = '0;
    logic          load_we = 1'b0;
    logic [1:0]    load_sel = '0;
    logic [3:0]    load_ch = '0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_wdata = '0;
    logic          stim_valid;
    logic          stim_ready = 1'b0;
    logic [W-1:0]  data_out, tap_out, bias_out;
    logic          res_valid = 1'b0;
    logic [W-1:0]  res_data = '0;
    logic [AW-1:0] cap_addr = '0;
    logic [W-1:0]  cap_rdata;
    logic [AW:0]   cap_count;
    logic          busy, done, timeout;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int k, run_len, mode, drop_last, start_cyc;
    int first_valid_cyc, first_xfer_edge, last_xfer_edge, last_res_edge, done_edge, stall_err;
    logic [31:0]    bias3;
    logic           pv [5];
    logic [W-1:0]   pd [5];
    logic           prev_valid = 1'b0;
    logic           prev_xfer = 1'b0;
    logic [3*W-1:0] prev_pay = '0;

    always #5 clk = ~clk;

    neuron_stream_seq #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .BIAS_LAG(1), .DRAIN_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .load_we(load_we), .load_sel(load_sel), .load_ch(load_ch),
        .load_addr(load_addr), .load_wdata(load_wdata),
        .stim_valid(stim_valid), .stim_ready(stim_ready),
        .data_out(data_out), .tap_out(tap_out), .bias_out(bias_out),
        .res_valid(res_valid), .res_data(res_data),
        .cap_addr(cap_addr), .cap_rdata(cap_rdata), .cap_count(cap_count),
        .busy(busy), .done(done), .timeout(timeout)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // channel c of vector i holds c*0x1000 + base + i
    function automatic logic [W-1:0] vec(input int base, input int i);
        logic [W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[32*c +: 32] = 32'(c * 32'h1000 + base + i);
        return v;
    endfunction

    task automatic step();
        logic xfer;
        if (prev_valid && !prev_xfer && (!stim_valid || {data_out, tap_out, bias_out} != prev_pay))
            stall_err++;
        res_valid = pv[4];
        res_data  = pd[4];
        if (res_valid) last_res_edge = cyc;
        stim_ready = (mode != 0) ? ~stim_ready : 1'b1;
        xfer = stim_valid && stim_ready;
        if (stim_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (xfer) begin
            check("beat_data", data_out, vec(0, k));
            check("beat_tap", tap_out, vec('h200, k));
            check("beat_bias", bias_out, (k >= 1) ? vec('h100, k - 1) : '0);
            if (k == 3) bias3 = bias_out[31:0];
            if (first_xfer_edge < 0) first_xfer_edge = cyc;
            last_xfer_edge = cyc;
        end
        for (int i = 4; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = xfer && !(drop_last != 0 && k == run_len - 1);
        pd[0] = data_out;
        if (xfer) k++;
        prev_valid = stim_valid;
        prev_xfer  = xfer;
        prev_pay   = {data_out, tap_out, bias_out};
        @(negedge clk);
        cyc++;
    endtask

    task automatic load(input logic [1:0] sel, input logic [3:0] ch, input logic [3:0] addr,
                        input logic [31:0] wd);
        load_we = 1'b1; load_sel = sel; load_ch = ch; load_addr = addr; load_wdata = wd;
        step();
        load_we = 1'b0;
    endtask

    task automatic pulse_start(input int l, input int m, input int d);
        k = 0; run_len = (l == 0) ? DEPTH : l; mode = m; drop_last = d;
        first_valid_cyc = -1; first_xfer_edge = -1; last_xfer_edge = -1;
        last_res_edge = -1; done_edge = -1; stall_err = 0; bias3 = '0;
        for (int i = 0; i < 5; i++) pv[i] = 1'b0;
        start = 1'b1; length = (AW + 1)'(l); start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && !done; i++) step();
        check({tag, "_done"}, W'(done), W'(1));
        done_edge = cyc - 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mode = 0; drop_last = 0; k = 0; run_len = 0; stall_err = 0;
        for (int i = 0; i < 5; i++) begin pv[i] = 1'b0; pd[i] = '0; end
        repeat (2) @(negedge clk);
        check("rst_valid", W'(stim_valid), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_timeout", W'(timeout), '0);
        check("rst_count", W'(cap_count), '0);
        check("rst_data", data_out, '0);
        reset = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++)
            for (int c = 0; c < NUM_CH; c++) begin
                load(2'd0, 4'(c), 4'(i), 32'(c * 32'h1000 + i));
                load(2'd1, 4'(c), 4'(i), 32'(c * 32'h1000 + 'h200 + i));
                load(2'd2, 4'(c), 4'(i), 32'(c * 32'h1000 + 'h100 + i));
            end

        // full-rate run with echo
        pulse_start(8, 0, 0);
        wait_done("t1");
        check("t1_first_valid", W'(first_valid_cyc - start_cyc), W'(2));
        check("t1_burst", W'(last_xfer_edge - first_xfer_edge), W'(7));
        check("t1_done_lat", W'(done_edge - last_xfer_edge), W'(5));
        check("t1_count", W'(cap_count), W'(8));
        check("t1_timeout", W'(timeout), '0);
        check("t1_busy", W'(busy), '0);
        check("t1_bias3", W'(bias3), W'('h102));
        for (int i = 0; i < 8; i++) begin
            cap_addr = 4'(i);
            step();
            check("t1_cap", cap_rdata, vec(0, i));
        end

        // back-pressure: ready toggles every cycle
        pulse_start(8, 1, 0);
        wait_done("t2");
        check("t2_beats", W'(k), W'(8));
        check("t2_stall", W'(stall_err), '0);
        check("t2_count", W'(cap_count), W'(8));
        check("t2_done_lat", W'(done_edge - last_xfer_edge), W'(5));

        // last result dropped -> drain timeout
        pulse_start(8, 0, 1);
        wait_done("t3");
        check("t3_timeout", W'(timeout), W'(1));
        check("t3_to_lat", W'(done_edge - last_res_edge), W'(16));
        check("t3_count", W'(cap_count), W'(7));

        // reset mid-run, then a short run
        pulse_start(8, 0, 0);
        for (int i = 0; i < 50 && k < 3; i++) step();
        reset = 1'b0;
        #1;
        check("t4_rst_valid", W'(stim_valid), '0);
        check("t4_rst_busy", W'(busy), '0);
        step();
        check("t4_rst_valid2", W'(stim_valid), '0);
        reset = 1'b1;
        step();
        pulse_start(2, 0, 0);
        wait_done("t4");
        check("t4_beats", W'(k), W'(2));
        check("t4_count", W'(cap_count), W'(2));
        check("t4_timeout", W'(timeout), '0);

        // out-of-range channel, reserved select, length 0, start and load while busy
        load(2'd0, 4'd5, 4'd0, 32'hDEAD_BEEF);
        load(2'd3, 4'd0, 4'd1, 32'hDEAD_BEEF);
        pulse_start(0, 0, 0);
        repeat (3) step();
        start = 1'b1; length = 5'd3;
        load_we = 1'b1; load_sel = 2'd0; load_ch = 4'd0; load_addr = 4'd15; load_wdata = 32'hBAD;
        step();
        start = 1'b0; load_we = 1'b0;
        wait_done("t5");
        check("t5_beats", W'(k), W'(16));
        check("t5_count", W'(cap_count), W'(16));
        check("t5_timeout", W'(timeout), '0);
        cap_addr = 4'd15;
        step();
        check("t5_cap15", cap_rdata, vec(0, 15));
        cap_addr = 4'd0;
        step();
        check("t5_cap0", cap_rdata, vec(0, 0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
